uart_rx_stream: RTL

- Fabric-side UART receiver: the far end of the Nios FIFOed UART transmit line (fifoed_avalon_uart_0_external_connection_txd).
- Recovers 8N1 serial frames, buffers received bytes in a small FIFO and presents them on a valid/ready byte stream for fabric logic, e.g. LED/command decoders.
- Reports framing errors and FIFO overruns as single-cycle pulses.

---
 rtl/uart_rx_stream.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver feeding a first-word-fall-through byte
// FIFO with a valid/ready output stream. Framing errors and FIFO overruns
// are reported as single-cycle pulses.
module uart_rx_stream #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Synchronizer and receive FSM state
    logic [1:0]       sync_q, sync_d;
    logic             rxd_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             frame_bad;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             pop;
    logic             full;
    logic             wr_en;

    // Two-flop synchronizer; the line idles high so the flops reset to 1.
    always_comb begin
        sync_d = {sync_q[0], uart_rxd};
    end

    assign rxd_s = sync_q[1];

    // Synchronizer register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Receive FSM: bit timing, mid-bit sampling and frame acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        // Return to IDLE at once so back-to-back frames work.
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Receive FSM registers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // FIFO control: a push at full is accepted only when a pop frees a slot.
    always_comb begin
        pop      = (count_q != '0) && rx_ready;
        full     = (count_q == CNT_FULL);
        wr_en    = push && (!full || pop);
        ov_d     = push && full && !pop;
        fe_d     = frame_bad;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and event pulse registers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mem_q    <= '{default: 8'h00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
        end
    end

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign fifo_count  = count_q;
    assign framing_err = fe_q;
    assign overrun     = ov_q;

endmodule
